// File: rtl/ttio_icb_port_resp.sv
// ttio_icb_port_resp: ICB responder for the TTIO port space.
//   Holds NPORT writable output words (driven on io_o) and NPORT read-only
//   input words (registered copies of io_i). Commands are answered in order
//   through a RSP_DEPTH-entry response FIFO, so several can be outstanding.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   icb_cmd_*         command channel (valid/ready, addr, read, wdata, wmask, size, itag)
//   icb_rsp_*         response channel (valid/ready, err, excl_ok, rdata, itag)
//   io_i              input-port pins, word k at [32k+31:32k]
//   io_o              output-port registers, same packing
module ttio_icb_port_resp #(
  parameter int unsigned NPORT     = 4,
  parameter int unsigned RSP_DEPTH = 2,
  parameter int unsigned ITAG_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icb_cmd_valid,
  output logic                  icb_cmd_ready,
  input  logic [31:0]           icb_cmd_addr,
  input  logic                  icb_cmd_read,
  input  logic [31:0]           icb_cmd_wdata,
  input  logic [3:0]            icb_cmd_wmask,
  input  logic [1:0]            icb_cmd_size,
  input  logic [ITAG_W-1:0]     icb_cmd_itag,
  output logic                  icb_rsp_valid,
  input  logic                  icb_rsp_ready,
  output logic                  icb_rsp_err,
  output logic                  icb_rsp_excl_ok,
  output logic [31:0]           icb_rsp_rdata,
  output logic [ITAG_W-1:0]     icb_rsp_itag,
  input  logic [NPORT*32-1:0]   io_i,
  output logic [NPORT*32-1:0]   io_o
);

  localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  // Port storage
  logic [31:0] out_q [NPORT];
  logic [31:0] out_d [NPORT];
  logic [31:0] in_q  [NPORT];

  // Response FIFO storage
  logic              err_mem_q   [RSP_DEPTH];
  logic [31:0]       rdata_mem_q [RSP_DEPTH];
  logic [ITAG_W-1:0] itag_mem_q  [RSP_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Decode
  logic [5:0]  idx;
  logic        hi_zero;
  logic        out_hit;
  logic        in_hit;
  logic        misalign;
  logic        cmd_err;
  logic [31:0] rd_word;
  logic [31:0] cmd_rdata;

  logic full;
  logic push;
  logic pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    ptr_inc = (p == PtrW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    idx      = {2'b00, icb_cmd_addr[5:2]};
    hi_zero  = (icb_cmd_addr[31:6] == '0);
    out_hit  = hi_zero && (idx < 6'(NPORT));
    in_hit   = hi_zero && (idx >= 6'(NPORT)) && (idx < 6'(2 * NPORT));
    misalign = ((icb_cmd_size == 2'd1) && icb_cmd_addr[0]) ||
               ((icb_cmd_size == 2'd2) && (icb_cmd_addr[1:0] != 2'b00));
    cmd_err  = !(out_hit || in_hit) || misalign || (icb_cmd_size == 2'd3) ||
               (!icb_cmd_read && in_hit);

    rd_word = '0;
    for (int k = 0; k < int'(NPORT); k++) begin
      if (idx == 6'(k))         rd_word = out_q[k];
      if (idx == 6'(NPORT + k)) rd_word = in_q[k];
    end
    cmd_rdata = (icb_cmd_read && !cmd_err) ? rd_word : '0;
  end

  // Handshake; a full FIFO still accepts when the head leaves this cycle
  always_comb begin
    full          = (cnt_q == CntW'(RSP_DEPTH));
    icb_rsp_valid = (cnt_q != '0);
    pop           = icb_rsp_valid && icb_rsp_ready;
    icb_cmd_ready = !full || pop;
    push          = icb_cmd_valid && icb_cmd_ready;
  end

  // Output-port byte writes
  always_comb begin
    for (int k = 0; k < int'(NPORT); k++) begin
      out_d[k] = out_q[k];
    end
    if (push && !icb_cmd_read && !cmd_err) begin
      for (int k = 0; k < int'(NPORT); k++) begin
        if (idx == 6'(k)) begin
          for (int b = 0; b < 4; b++) begin
            if (icb_cmd_wmask[b]) out_d[k][8*b +: 8] = icb_cmd_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CntW'(1);
    else if (pop && !push) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int k = 0; k < int'(NPORT); k++) begin
        out_q[k] <= '0;
        in_q[k]  <= '0;
      end
      for (int e = 0; e < int'(RSP_DEPTH); e++) begin
        err_mem_q[e]   <= 1'b0;
        rdata_mem_q[e] <= '0;
        itag_mem_q[e]  <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      for (int k = 0; k < int'(NPORT); k++) begin
        out_q[k] <= out_d[k];
        in_q[k]  <= io_i[32*k +: 32];
      end
      if (push) begin
        err_mem_q[wr_ptr_q]   <= cmd_err;
        rdata_mem_q[wr_ptr_q] <= cmd_rdata;
        itag_mem_q[wr_ptr_q]  <= icb_cmd_itag;
      end
    end
  end

  // Response fields come straight from FIFO registers, never from the command
  always_comb begin
    icb_rsp_err     = err_mem_q[rd_ptr_q];
    icb_rsp_rdata   = rdata_mem_q[rd_ptr_q];
    icb_rsp_itag    = itag_mem_q[rd_ptr_q];
    icb_rsp_excl_ok = 1'b0;
    for (int k = 0; k < int'(NPORT); k++) begin
      io_o[32*k +: 32] = out_q[k];
    end
  end

endmodule

// File: tb/tb_ttio_icb_port_resp.sv
module tb_ttio_icb_port_resp;

  localparam int NP    = 4;
  localparam int DEPTH = 2;
  localparam int IW    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [31:0]       cmd_addr;
  logic              cmd_read;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_wmask;
  logic [1:0]        cmd_size;
  logic [IW-1:0]     cmd_itag;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_err;
  logic              rsp_excl_ok;
  logic [31:0]       rsp_rdata;
  logic [IW-1:0]     rsp_itag;
  logic [NP*32-1:0]  io_i;
  logic [NP*32-1:0]  io_o;

  ttio_icb_port_resp #(
    .NPORT    (NP),
    .RSP_DEPTH(DEPTH),
    .ITAG_W   (IW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .icb_cmd_valid  (cmd_valid),
    .icb_cmd_ready  (cmd_ready),
    .icb_cmd_addr   (cmd_addr),
    .icb_cmd_read   (cmd_read),
    .icb_cmd_wdata  (cmd_wdata),
    .icb_cmd_wmask  (cmd_wmask),
    .icb_cmd_size   (cmd_size),
    .icb_cmd_itag   (cmd_itag),
    .icb_rsp_valid  (rsp_valid),
    .icb_rsp_ready  (rsp_ready),
    .icb_rsp_err    (rsp_err),
    .icb_rsp_excl_ok(rsp_excl_ok),
    .icb_rsp_rdata  (rsp_rdata),
    .icb_rsp_itag   (rsp_itag),
    .io_i           (io_i),
    .io_o           (io_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          err;
    logic [31:0]   rdata;
    logic [IW-1:0] itag;
  } rsp_t;

  // Behavioural model: a queue of pending responses plus the port words
  rsp_t        mq[$];
  rsp_t        seen[$];
  logic [31:0] m_out[NP];
  logic [31:0] m_in[NP];
  bit          started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return (mq.size() < DEPTH) || (mq.size() > 0 && rsp_ready);
  endfunction

  function automatic bit model_err(input logic [31:0] a, input logic rd, input logic [1:0] sz);
    int i;
    bit e;
    i = int'(a[5:2]);
    e = 0;
    if (a >= 32'd64 || i >= 2 * NP) e = 1;
    if (sz == 2'd3) e = 1;
    if (sz == 2'd1 && a[0]) e = 1;
    if (sz == 2'd2 && a[1:0] != 2'b00) e = 1;
    if (!rd && i >= NP) e = 1;
    return e;
  endfunction

  always @(posedge clk) begin
    bit   p;
    bit   acc;
    rsp_t r;
    int   i;
    if (rst) begin
      mq.delete();
      for (int k = 0; k < NP; k++) begin
        m_out[k] = '0;
        m_in[k]  = '0;
      end
      started = 1;
    end else if (started) begin
      p   = (mq.size() > 0) && rsp_ready;
      acc = cmd_valid && model_ready();
      r   = '0;
      if (acc) begin
        i      = int'(cmd_addr[5:2]);
        r.err  = model_err(cmd_addr, cmd_read, cmd_size);
        r.itag = cmd_itag;
        if (!r.err && cmd_read) r.rdata = (i < NP) ? m_out[i] : m_in[i - NP];
        if (!r.err && !cmd_read) begin
          for (int b = 0; b < 4; b++)
            if (cmd_wmask[b]) m_out[i][8*b +: 8] = cmd_wdata[8*b +: 8];
        end
      end
      if (p) void'(mq.pop_front());
      if (acc) mq.push_back(r);
      for (int k = 0; k < NP; k++) m_in[k] = io_i[32*k +: 32];
    end
  end

  // Compare process: every cycle once reset has been seen
  always @(negedge clk) begin
    if (started) begin
      chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, model_ready()});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, mq.size() > 0});
      chk("excl_ok", {31'b0, rsp_excl_ok}, 32'd0);
      for (int k = 0; k < NP; k++) chk("io_o", io_o[32*k +: 32], m_out[k]);
      if (mq.size() > 0) begin
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, mq[0].err});
        chk("rsp_rdata", rsp_rdata, mq[0].rdata);
        chk("rsp_itag", {24'b0, rsp_itag}, {24'b0, mq[0].itag});
        if (rsp_ready) seen.push_back({rsp_err, rsp_rdata, rsp_itag});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a command and hold it until accepted; returns cycles spent
  task automatic do_cmd(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] wm, input logic [1:0] sz, input logic [IW-1:0] tg,
                        output int waited);
    bit acc;
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_wmask = wm;
    cmd_size  = sz;
    cmd_itag  = tg;
    waited    = 0;
    acc       = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      step();
      waited++;
      if (acc) break;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: itag %0d not accepted in 20 cycles", tg);
    end
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
  endtask

  task automatic check_seen(input string name, input logic e, input logic [31:0] d,
                            input logic [IW-1:0] tg);
    rsp_t r;
    if (seen.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no response observed, want itag %0d", name, tg);
    end else begin
      r = seen.pop_front();
      chk({name, "_err"}, {31'b0, r.err}, {31'b0, e});
      chk({name, "_rdata"}, r.rdata, d);
      chk({name, "_itag"}, {24'b0, r.itag}, {24'b0, tg});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_read  = 1'b0;
    cmd_wdata = '0;
    cmd_wmask = '0;
    cmd_size  = '0;
    cmd_itag  = '0;
    rsp_ready = 1'b1;
    io_i      = '0;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_io_o_lo", io_o[63:0] == '0, 32'd1);
    step();

    // 1: write OUT[1], read it back
    do_cmd(1'b0, 32'h04, 32'hDEADBEEF, 4'hF, 2'd2, 8'd1, w);
    do_cmd(1'b1, 32'h04, 32'h0, 4'h0, 2'd2, 8'd2, w);
    idle();
    @(negedge clk);
    chk("t1_io_o_word1", io_o[63:32], 32'hDEADBEEF);
    repeat (3) step();
    check_seen("t1_wr", 1'b0, 32'h0, 8'd1);
    check_seen("t1_rd", 1'b0, 32'hDEADBEEF, 8'd2);

    // 2: input read, write to IN region errors
    io_i[31:0]  = 32'h12345678;
    io_i[63:32] = 32'hCAFEF00D;
    step();
    do_cmd(1'b1, 32'h10, 32'h0, 4'h0, 2'd2, 8'd3, w);
    do_cmd(1'b0, 32'h10, 32'hFFFFFFFF, 4'hF, 2'd2, 8'd4, w);
    idle();
    repeat (3) step();
    check_seen("t2_rd_in", 1'b0, 32'h12345678, 8'd3);
    check_seen("t2_wr_in", 1'b1, 32'h0, 8'd4);
    chk("t2_io_o_word0", io_o[31:0], 32'h0);

    // 3: lane-placed byte write into OUT[2]; misaligned half write errors
    do_cmd(1'b0, 32'h0A, 32'h00AA00AA, 4'b0100, 2'd0, 8'd5, w);
    do_cmd(1'b0, 32'h01, 32'hFFFFFFFF, 4'hF, 2'd1, 8'd6, w);
    idle();
    repeat (3) step();
    check_seen("t3_byte", 1'b0, 32'h0, 8'd5);
    check_seen("t3_half", 1'b1, 32'h0, 8'd6);
    chk("t3_io_o_word2", io_o[95:64], 32'h00AA0000);
    chk("t3_io_o_word0", io_o[31:0], 32'h0);

    // 4: backpressure fills the FIFO; third command waits for a pop
    rsp_ready = 1'b0;
    do_cmd(1'b1, 32'h08, 32'h0, 4'h0, 2'd2, 8'd7, w);
    do_cmd(1'b1, 32'h00, 32'h0, 4'h0, 2'd2, 8'd8, w);
    cmd_valid = 1'b1;
    cmd_read  = 1'b1;
    cmd_addr  = 32'h14;
    cmd_itag  = 8'd9;
    @(negedge clk);
    chk("t4_full_ready0", {31'b0, cmd_ready}, 32'd0);
    step();
    @(negedge clk);
    chk("t4_full_ready1", {31'b0, cmd_ready}, 32'd0);
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_pop_ready", {31'b0, cmd_ready}, 32'd1);
    step();
    idle();
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("t4_still_valid", {31'b0, rsp_valid}, 32'd1);
    step();
    rsp_ready = 1'b1;
    repeat (3) step();
    check_seen("t4_a", 1'b0, 32'h00AA0000, 8'd7);
    check_seen("t4_b", 1'b0, 32'h0, 8'd8);
    check_seen("t4_c", 1'b0, 32'hCAFEF00D, 8'd9);

    // 5: out-of-range and illegal size; reset drops pending responses
    do_cmd(1'b1, 32'h40, 32'h0, 4'h0, 2'd2, 8'd10, w);
    do_cmd(1'b1, 32'h00, 32'h0, 4'h0, 2'd3, 8'd11, w);
    idle();
    repeat (3) step();
    check_seen("t5_range", 1'b1, 32'h0, 8'd10);
    check_seen("t5_size3", 1'b1, 32'h0, 8'd11);
    rsp_ready = 1'b0;
    do_cmd(1'b1, 32'h04, 32'h0, 4'h0, 2'd2, 8'd12, w);
    do_cmd(1'b1, 32'h08, 32'h0, 4'h0, 2'd2, 8'd13, w);
    idle();
    @(negedge clk);
    chk("t5_pending", {31'b0, rsp_valid}, 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("t5_rst_io_o", io_o[127:64] == '0 && io_o[63:0] == '0, 32'd1);
    chk("t5_rst_ready", {31'b0, cmd_ready}, 32'd1);
    rsp_ready = 1'b1;
    step();

    // 6: back-to-back write/read at one accept per cycle
    do_cmd(1'b0, 32'h00, 32'h11223344, 4'hF, 2'd2, 8'd20, w);
    chk("t6_w0_cycles", w, 32'd1);
    do_cmd(1'b1, 32'h00, 32'h0, 4'h0, 2'd2, 8'd21, w);
    chk("t6_r0_cycles", w, 32'd1);
    do_cmd(1'b0, 32'h00, 32'h55667788, 4'b0011, 2'd2, 8'd22, w);
    chk("t6_w1_cycles", w, 32'd1);
    do_cmd(1'b1, 32'h00, 32'h0, 4'h0, 2'd2, 8'd23, w);
    chk("t6_r1_cycles", w, 32'd1);
    idle();
    repeat (3) step();
    check_seen("t6_w0", 1'b0, 32'h0, 8'd20);
    check_seen("t6_r0", 1'b0, 32'h11223344, 8'd21);
    check_seen("t6_w1", 1'b0, 32'h0, 8'd22);
    check_seen("t6_r1", 1'b0, 32'h11227788, 8'd23);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
